// File: rtl/cpu_run_ctrl.sv
// ============================================================================
// cpu_run_ctrl
// ----------------------------------------------------------------------------
// Run controller for the pipelined RV32I core. A start request holds the core
// in reset for RST_CYCLES cycles. The core then runs until either its fetch PC
// sits still for HALT_STABLE consecutive compares (halt) or MAX_CYCLES run
// cycles elapse (timeout). While running it counts cycles and store cycles.
// At the end of the run it latches x31 and the final PC.
//
// Optional feature macro: RUN_PC_HIST_EN
//   When defined, a 4-entry history of PC changes is kept. hist_idx selects
//   an entry (0 = most recent) and hist_pc returns it combinationally.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset of this block
//   start        begin a run (honoured in IDLE or DONE only)
//   pc           core fetch PC
//   x31          core register x31
//   we           core data-store byte enables
//   cpu_rst      reset to the core, high in every state except RUN
//   running      high while the core runs
//   done         high once a run has finished
//   halted       run ended by a PC self-loop
//   timeout      run ended by the cycle limit
//   cycle_count  run cycles elapsed
//   store_count  run cycles with any byte enable set (saturating)
//   result       x31 captured at run end
//   final_pc     pc captured at run end
//   hist_idx     (RUN_PC_HIST_EN) history entry select
//   hist_pc      (RUN_PC_HIST_EN) selected history entry
// ============================================================================
module cpu_run_ctrl #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int CNT_W       = 32,
    parameter int RST_CYCLES  = 10,
    parameter int MAX_CYCLES  = 1002,
    parameter int HALT_STABLE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W-1:0]   pc,
    input  logic [DATA_W-1:0] x31,
    input  logic [3:0]        we,
    output logic              cpu_rst,
    output logic              running,
    output logic              done,
    output logic              halted,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  store_count,
    output logic [DATA_W-1:0] result,
    output logic [PC_W-1:0]   final_pc
`ifdef RUN_PC_HIST_EN
    ,
    input  logic [1:0]        hist_idx,
    output logic [PC_W-1:0]   hist_pc
`endif
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int STB_W = (HALT_STABLE > 1) ? $clog2(HALT_STABLE) : 1;
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(HALT_STABLE - 1);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

    state_t            state;
    logic [PC_W-1:0]   prev_pc;
    logic              prev_valid;
    logic [STB_W-1:0]  stable_cnt;
    logic [RST_W-1:0]  rst_cnt;

    logic pc_same;
    logic halt_hit;
    logic time_hit;
    logic store_sat;

    // stable_cnt holds the number of equal compares already seen, so the
    // compare made on this edge is the HALT_STABLE-th one when it reaches
    // HALT_STABLE-1.
    assign pc_same   = prev_valid && (pc == prev_pc);
    assign halt_hit  = pc_same && (stable_cnt == STB_LAST);
    assign time_hit  = (cycle_count == CYC_LAST);
    assign store_sat = &store_count;

`ifdef RUN_PC_HIST_EN
    logic [PC_W-1:0] hist_buf [4];
    logic [1:0]      hist_wr;
    logic [1:0]      hist_rd;

    // hist_wr points at the next slot to write, so the newest entry sits one
    // slot behind it and older entries further back.
    assign hist_rd = hist_wr - 2'd1 - hist_idx;

    always_comb begin
        hist_pc = hist_buf[hist_rd];
    end
`else
    // No PC history is kept in this build.
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cpu_rst     <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            store_count <= '0;
            result      <= '0;
            final_pc    <= '0;
            prev_pc     <= '0;
            prev_valid  <= 1'b0;
            stable_cnt  <= '0;
            rst_cnt     <= '0;
`ifdef RUN_PC_HIST_EN
            hist_wr     <= '0;
            for (int i = 0; i < 4; i++) hist_buf[i] <= '0;
`endif
        end else begin
            case (state)
                // A new run may be launched from idle or after a finished
                // run; everything observable from the previous run is wiped.
                IDLE, DONE: begin
                    if (start) begin
                        state       <= RESET;
                        cpu_rst     <= 1'b1;
                        running     <= 1'b0;
                        done        <= 1'b0;
                        halted      <= 1'b0;
                        timeout     <= 1'b0;
                        cycle_count <= '0;
                        store_count <= '0;
                        result      <= '0;
                        final_pc    <= '0;
                        prev_pc     <= '0;
                        prev_valid  <= 1'b0;
                        stable_cnt  <= '0;
                        rst_cnt     <= '0;
`ifdef RUN_PC_HIST_EN
                        hist_wr     <= '0;
                        for (int i = 0; i < 4; i++) hist_buf[i] <= '0;
`endif
                    end
                end

                RESET: begin
                    rst_cnt <= rst_cnt + 1'b1;
                    if (rst_cnt == RST_LAST) begin
                        state   <= RUN;
                        cpu_rst <= 1'b0;
                        running <= 1'b1;
                    end
                end

                // The exit edge still counts as a run cycle, so the counters
                // update unconditionally before the exit checks.
                RUN: begin
                    cycle_count <= cycle_count + 1'b1;
                    if ((we != 4'b0000) && !store_sat) begin
                        store_count <= store_count + 1'b1;
                    end
                    prev_pc    <= pc;
                    prev_valid <= 1'b1;
                    stable_cnt <= pc_same ? stable_cnt + 1'b1 : '0;
`ifdef RUN_PC_HIST_EN
                    if (prev_valid && (pc != prev_pc)) begin
                        hist_buf[hist_wr] <= pc;
                        hist_wr           <= hist_wr + 2'd1;
                    end
`endif
                    if (halt_hit || time_hit) begin
                        state    <= DONE;
                        cpu_rst  <= 1'b1;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        halted   <= halt_hit;
                        timeout  <= !halt_hit;
                        result   <= x31;
                        final_pc <= pc;
                    end
                end

                default: begin
                    state   <= IDLE;
                    cpu_rst <= 1'b1;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// ============================================================================
// tb_cpu_run_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for cpu_run_ctrl. Each run is described up front as a
// per-cycle table of pc / x31 / we values. The expected end of the run is
// derived from that table by scanning for runs of repeated PCs and the cycle
// limit, and the expected counts are tallied from the same table.
// ============================================================================
module tb_cpu_run_ctrl;

    localparam int MAXC = 1002;
    localparam int RSTC = 10;
    localparam int HSTB = 8;
    localparam int LEN  = 1100;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [31:0] x31;
    logic [3:0]  we;
    logic        cpu_rst;
    logic        running;
    logic        done;
    logic        halted;
    logic        timeout;
    logic [31:0] cycle_count;
    logic [31:0] store_count;
    logic [31:0] result;
    logic [31:0] final_pc;
`ifdef RUN_PC_HIST_EN
    logic [1:0]  hist_idx = 2'd0;
    logic [31:0] hist_pc;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] pc_seq [LEN];
    logic [31:0] x_seq  [LEN];
    logic [3:0]  we_seq [LEN];
    int          fill_idx;

    cpu_run_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .pc          (pc),
        .x31         (x31),
        .we          (we),
        .cpu_rst     (cpu_rst),
        .running     (running),
        .done        (done),
        .halted      (halted),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .store_count (store_count),
        .result      (result),
        .final_pc    (final_pc)
`ifdef RUN_PC_HIST_EN
        ,
        .hist_idx    (hist_idx),
        .hist_pc     (hist_pc)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Append n copies of v to the pc table.
    task automatic pushPc(input logic [31:0] v, input int n);
        for (int j = 0; j < n && fill_idx < LEN; j++) begin
            pc_seq[fill_idx] = v;
            fill_idx++;
        end
    endtask

    // Where does the run end? It halts on the cycle that completes HSTB
    // consecutive repeats of the previous PC, otherwise at the cycle limit.
    function automatic void modelRun(output int end_idx, output bit by_halt);
        int repeats = 0;
        end_idx = MAXC - 1;
        by_halt = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            if (i > 0 && pc_seq[i] == pc_seq[i-1]) repeats++;
            else repeats = 0;
            if (repeats == HSTB) begin
                end_idx = i;
                by_halt = 1'b1;
                return;
            end
        end
    endfunction

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_cpu_rst"}, cpu_rst, 1);
        checkOutput({tag, "_running"}, running, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_cycles"}, cycle_count, 0);
        checkOutput({tag, "_stores"}, store_count, 0);
    endtask

    // Launch a run from the current table. mid_start (<k) pulses start during
    // the run; abort_at aborts the run with rst after that run cycle.
    task automatic applyStimulus(input int mid_start, input int abort_at);
        int k;
        bit by_halt;
        int stores;
        modelRun(k, by_halt);
        stores = 0;

        @(negedge clk);
        start = 1'b1;
        for (int c = 0; c < RSTC; c++) begin
            @(negedge clk);
            start = 1'b0;
            pc    = $urandom;
            we    = 4'($urandom);
            x31   = $urandom;
            checkOutput("reset_cpu_rst", cpu_rst, 1);
            checkOutput("reset_running", running, 0);
        end

        @(negedge clk);
        checkOutput("run_cpu_rst", cpu_rst, 0);
        checkOutput("run_running", running, 1);
        checkOutput("run_cycles0", cycle_count, 0);
        pc  = pc_seq[0];
        x31 = x_seq[0];
        we  = we_seq[0];

        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            if (we_seq[i] != 4'b0000) stores++;
            start = (i == mid_start);
            checkOutput("cycle_count", cycle_count, i + 1);
            checkOutput("done_flag", done, (i == k));
            checkOutput("running_flag", running, (i != k));
            if (i == abort_at) begin
`ifdef RUN_PC_HIST_EN
                begin
                    logic [31:0] chg [$];
                    for (int j = 1; j <= i; j++)
                        if (pc_seq[j] != pc_seq[j-1]) chg.push_back(pc_seq[j]);
                    for (int h = 0; h < 4; h++) begin
                        hist_idx = 2'(h);
                        #1;
                        checkOutput("hist_pc", hist_pc, (h < chg.size()) ? chg[chg.size()-1-h] : 32'h0);
                    end
                end
`endif
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                checkIdle("abort");
                checkOutput("abort_result", result, 0);
                checkOutput("abort_final_pc", final_pc, 0);
`ifdef RUN_PC_HIST_EN
                for (int h = 0; h < 4; h++) begin
                    hist_idx = 2'(h);
                    #1;
                    checkOutput("hist_cleared", hist_pc, 0);
                end
`endif
                return;
            end
            if (i < k) begin
                pc  = pc_seq[i+1];
                x31 = x_seq[i+1];
                we  = we_seq[i+1];
            end
        end
        start = 1'b0;

        checkOutput("end_cpu_rst", cpu_rst, 1);
        checkOutput("end_halted", halted, by_halt);
        checkOutput("end_timeout", timeout, !by_halt);
        checkOutput("end_stores", store_count, stores);
        checkOutput("end_result", result, x_seq[k]);
        checkOutput("end_final_pc", final_pc, pc_seq[k]);

        // DONE must hold its outputs regardless of the core's inputs.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            pc  = $urandom;
            x31 = $urandom;
            we  = 4'($urandom);
            checkOutput("hold_done", done, 1);
            checkOutput("hold_cycles", cycle_count, k + 1);
            checkOutput("hold_result", result, x_seq[k]);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pc    = '0;
        x31   = '0;
        we    = '0;
        repeat (3) @(negedge clk);
        checkIdle("in_rst");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            pc = $urandom;
            we = 4'($urandom);
            checkIdle("idle");
        end

        // Steadily advancing PC: the run must end on the cycle limit.
        $display("[TB] timeout run");
        for (int i = 0; i < LEN; i++) begin
            pc_seq[i] = 32'(4 * i);
            x_seq[i]  = 32'h1234;
            we_seq[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
        end
        applyStimulus(-1, -1);

        // Short hold that must not halt, then a self-loop at 0x40.
        $display("[TB] halt run");
        fill_idx = 0;
        pushPc(32'h0, 1);
        pushPc(32'h4, 1);
        pushPc(32'h8, 1);
        pushPc(32'hC, 5);
        for (int a = 'h10; a < 'h40; a += 4) pushPc(32'(a), 1);
        pushPc(32'h40, LEN);
        for (int i = 0; i < LEN; i++) begin
            x_seq[i]  = 32'h2A;
            we_seq[i] = 4'($urandom);
        end
        applyStimulus(-1, -1);

        // Three store cycles, a seven-repeat hold just short of halting and a
        // start pulse in the middle of the run.
        $display("[TB] store run");
        fill_idx = 0;
        for (int a = 0; a <= 'h20; a += 4) pushPc(32'(a), 1);
        pushPc(32'h24, 8);
        pushPc(32'h28, LEN);
        for (int i = 0; i < LEN; i++) begin
            x_seq[i]  = $urandom;
            we_seq[i] = (i == 2 || i == 5 || i == 9) ? 4'b0011 : 4'b0000;
        end
        applyStimulus(6, -1);

        // rst from DONE wipes latched results.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkIdle("rst_done");
        checkOutput("rst_done_result", result, 0);
        checkOutput("rst_done_final_pc", final_pc, 0);
        checkOutput("rst_done_halted", halted, 0);

        // Abort mid-run with rst.
        $display("[TB] abort run");
        fill_idx = 0;
        pushPc(32'h0, 1);
        pushPc(32'h4, 1);
        pushPc(32'h8, 2);
        for (int a = 'hC; fill_idx < LEN; a += 4) pushPc(32'(a), 1);
        for (int i = 0; i < LEN; i++) begin
            x_seq[i]  = $urandom;
            we_seq[i] = 4'($urandom);
        end
        applyStimulus(-1, 4);

        // Random programs built from PC holds of random length.
        for (int r = 0; r < 4; r++) begin
            $display("[TB] random run %0d", r);
            fill_idx = 0;
            while (fill_idx < LEN) pushPc(32'($urandom_range(0, 3) * 4), $urandom_range(1, 10));
            for (int i = 0; i < LEN; i++) begin
                x_seq[i]  = $urandom;
                we_seq[i] = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0000;
            end
            applyStimulus(3, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
